// File: rtl/aes_inv_shift_sub.sv
// Inverse ShiftRows then InvSubBytes over a 128-bit AES state, LANES bytes per cycle; result N+1 cycles after accept.
// Result held in DONE until out_ready; a new block can be accepted on the same edge the result is taken.
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign y = TBL[a];
endmodule

module aes_inv_shift_sub #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [0:15][7:0] s, s_next, in_bytes, shifted;
  logic [3:0]      base;
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];
  logic            accept;

  assign in_bytes = in_data;

  // Byte k sits at row k%4, column k/4; row r rotates right by r columns.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[4*c + r] = in_bytes[4*((c - r + 4) % 4) + r];
      end
    end
  end

  assign base = 4'(int'(cnt) * LANES);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_in[g] = s[base + 4'(g)];
    aes_inv_sbox u_sbox (
      .a (lane_in[g]),
      .y (lane_out[g])
    );
  end

  assign in_ready = !rst && ((state == IDLE) || (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    s_next = s;
    if (accept) begin
      s_next = shifted;
    end else if (state == SUB) begin
      for (int i = 0; i < LANES; i++) begin
        s_next[base + 4'(i)] = lane_out[i];
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SUB;
          cnt_next   = '0;
        end
      end
      SUB: begin
        cnt_next = cnt + CW'(1);
        if (cnt == CW'(N - 1)) state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (accept) begin
            state_next = SUB;
            cnt_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      s     <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      s     <= s_next;
    end
  end

  assign out_valid = (state == DONE);
  assign out_data  = s;
  assign busy      = (state != IDLE);
endmodule

// File: doc/aes_inv_shift_sub.md
AES_INV_SHIFT_SUB -- requirements
Module: aes_inv_shift_sub

Interface
REQ-001 SHALL have parameter LANES, default 4, number of aes_inv_sbox instances used per cycle; legal values 4, 8, 16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  in_data holds a state block to process.
REQ-005 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-006 SHALL have port in_data  input  128  AES state, column-major: byte k = in_data[127-8k -: 8], row = k mod 4, col = k div 4.
REQ-007 SHALL have port out_valid  output  1  out_data holds a completed result.
REQ-008 SHALL have port out_ready  input  1  downstream takes out_data this cycle.
REQ-009 SHALL have port out_data  output  128  InvSubBytes(InvShiftRows(in_data)), same byte ordering as in_data.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL instantiate exactly LANES aes_inv_sbox instances and SHALL NOT use any other substitution table.
REQ-012 SHALL implement FSM states IDLE, SUB, DONE; N = 16/LANES substitution cycles per block.
REQ-013 Accept on a rising edge where in_valid && in_ready; SHALL capture InvShiftRows(in_data) into internal 128-bit state register S, clear pass counter cnt to 0, and enter SUB.
REQ-014 InvShiftRows SHALL map out[r][c] = in[r][(c - r) mod 4] for r, c in 0..3.
REQ-015 In SUB, each cycle SHALL replace bytes k = cnt*LANES .. cnt*LANES+LANES-1 of S with their inverse S-box values and then increment cnt.
REQ-016 SUB SHALL transition to DONE on the edge where cnt == N-1; cnt width is ceil(log2(N)) bits, minimum 1.
REQ-017 out_valid SHALL be 1 exactly in DONE; out_data SHALL equal S and SHALL stay stable while out_valid && !out_ready.
REQ-018 Latency: for acceptance at edge E, out_valid SHALL first be 1 in the cycle after edge E+N (LANES=4: 4 edges after acceptance).
REQ-019 in_ready SHALL be (state == IDLE) || (state == DONE && out_ready), and 0 while rst is 1.
REQ-020 DONE with out_ready && !in_valid SHALL go to IDLE; DONE with out_ready && in_valid SHALL complete the output handshake and accept the new block on the same edge, entering SUB (back-to-back throughput one block per N+1 cycles).
REQ-021 in_valid in SUB SHALL be ignored (not accepted, no state change); in_data need not remain stable after acceptance.
REQ-022 out_ready in IDLE or SUB SHALL have no effect.
REQ-023 Bytes of S not yet substituted SHALL hold their shifted values; substituted bytes SHALL NOT be substituted twice.

Reset
REQ-024 With rst high at an edge, SHALL set state IDLE, cnt 0, S 0; after that edge out_valid = 0, out_data = 0, busy = 0.
REQ-025 rst high mid-SUB or in DONE SHALL discard the block in progress; no out_valid pulse for it.
REQ-026 After rst is released, in_ready SHALL be 1 in the first cycle.

Verification
REQ-027 LANES=4, in_data = 128'h6363...63 accepted -> after 4 edges out_valid=1, out_data = 128'h0.
REQ-028 LANES=4, in_data = 128'h000102030405060708090a0b0c0d0e0f -> out_data = 128'h52f3a3383009d79ebf366afb8140a5d5.
REQ-029 Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_data unchanged, in_ready 0; then out_ready=1 -> one transfer, IDLE.
REQ-030 Back-to-back: in_valid held high with two blocks, out_ready=1 -> second accepted on the same edge the first is taken; out_valid spacing 5 cycles (LANES=4).
REQ-031 Assert rst two cycles after acceptance -> out_valid never rises for that block; next block processed correctly.
REQ-032 Repeat REQ-028 with LANES=8 and 16 -> identical out_data at latency 2 and 1 edges respectively; random 10k blocks vs. software model match.
